// File: rtl/dda_pkg.sv
// Shared types and default sizes for the DDA run controller and datapath.
package dda_pkg;

  localparam int DDA_N       = 16;
  localparam int DDA_STEP_W  = 16;
  localparam int DDA_DECIM_W = 8;

  // Sequencer states: IDLE waits for start, LOAD applies the ICs,
  // SAMPLE emits into the output buffer, STEP takes one Euler step,
  // DONE marks normal completion.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dda_sample_buf.sv
// Single-entry valid/ready sample register with capture and flush.
//
// Handshake: a sample transfers on a rising edge where valid && ready.
// While valid && !ready the held fields do not change. A capture on the
// same edge as a transfer replaces the entry and keeps valid high.
// Flush drops the entry and wins over capture.
module dda_sample_buf #(
  parameter int N      = 16,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              flush,
  input  logic              ready,
  input  logic [N-1:0]      v1_d,
  input  logic [N-1:0]      v2_d,
  input  logic [STEP_W-1:0] idx_d,
  output logic              valid,
  output logic [N-1:0]      v1,
  output logic [N-1:0]      v2,
  output logic [STEP_W-1:0] idx,
  output logic              free
);

  // The slot can take a new sample if empty or being drained this cycle.
  assign free = !valid || ready;

  // Buffer register: flush, then capture, then drain by transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      v1    <= '0;
      v2    <= '0;
      idx   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      v1    <= v1_d;
      v2    <= v2_d;
      idx   <= idx_d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dda_sequencer.sv
// Run controller for the spring-mass DDA: loads ICs, steps the Euler
// integrators num_steps times and emits decimated (v1, v2) samples,
// stalling integration while the sample buffer is blocked.
module dda_sequencer
  import dda_pkg::*;
#(
  parameter int N       = DDA_N,
  parameter int STEP_W  = DDA_STEP_W,
  parameter int DECIM_W = DDA_DECIM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic [DECIM_W-1:0] decim,
  output logic               dda_en,
  output logic               dda_init_n,
  input  logic [N-1:0]       v1_in,
  input  logic [N-1:0]       v2_in,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic [N-1:0]       smp_v1,
  output logic [N-1:0]       smp_v2,
  output logic [STEP_W-1:0]  smp_idx,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  seq_state_e          state, state_next;
  logic [STEP_W-1:0]   steps_q, step_cnt, step_inc;
  logic [DECIM_W-1:0]  decim_q, decim_cnt, decim_inc;
  logic                emit, aborted_q;
  logic                start_take, abort_take, decim_wrap;
  logic                capture, buf_free;

  assign start_take = (state == ST_IDLE) && start && !abort;
  assign abort_take = (state != ST_IDLE) && abort;
  assign step_inc   = step_cnt + STEP_W'(1);
  assign decim_inc  = decim_cnt + DECIM_W'(1);
  assign decim_wrap = (decim_inc == decim_q);
  assign busy       = (state != ST_IDLE);
  assign aborted    = aborted_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and per-state outputs; abort overrides everything.
  always_comb begin
    state_next = state;
    dda_en     = 1'b0;
    dda_init_n = 1'b1;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start_take) state_next = ST_LOAD;
      ST_LOAD: begin
        dda_en     = 1'b1;
        dda_init_n = 1'b0;
        state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        capture = emit && buf_free;
        if (!emit || buf_free)
          state_next = (step_cnt == steps_q) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        dda_en     = 1'b1;
        state_next = ST_SAMPLE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort_take) begin
      state_next = ST_IDLE;
      dda_en     = 1'b0;
      capture    = 1'b0;
      done       = 1'b0;
    end
  end

  // Run parameters, step/decimation counters and the emit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q   <= '0;
      decim_q   <= '0;
      step_cnt  <= '0;
      decim_cnt <= '0;
      emit      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_take;
      if (start_take) begin
        steps_q   <= num_steps;
        decim_q   <= (decim == '0) ? DECIM_W'(1) : decim;
        step_cnt  <= '0;
        decim_cnt <= '0;
      end
      if (state == ST_LOAD && !abort_take) emit <= 1'b1;
      if (state == ST_STEP && !abort_take) begin
        step_cnt  <= step_inc;
        decim_cnt <= decim_wrap ? '0 : decim_inc;
        // The final step is always emitted regardless of decimation.
        emit      <= decim_wrap || (step_inc == steps_q);
      end
    end
  end

  dda_sample_buf #(.N(N), .STEP_W(STEP_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .flush   (abort_take),
    .ready   (smp_ready),
    .v1_d    (v1_in),
    .v2_d    (v2_in),
    .idx_d   (step_cnt),
    .valid   (smp_valid),
    .v1      (smp_v1),
    .v2      (smp_v2),
    .idx     (smp_idx),
    .free    (buf_free)
  );

endmodule

// File: tb/tb_dda_sequencer.sv
// Bench for dda_sequencer with a toy integer datapath standing in for
// the posit integrators.
module tb_dda_sequencer;

  localparam int N = 16;
  localparam int SW = 16;
  localparam int DW = 8;

  logic          clk, rst_n, start, abort, smp_ready;
  logic [SW-1:0] num_steps, smp_idx;
  logic [DW-1:0] decim;
  logic          dda_en, dda_init_n, smp_valid, busy, done, aborted;
  logic [N-1:0]  v1_in, v2_in, smp_v1, smp_v2;
  logic [N-1:0]  ic1, ic2, dp_v1, dp_v2;

  logic [47:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int busy_cycles, done_cnt, en_cycles, init_cycles, acc_cnt;
  bit rand_ready = 0;

  dda_sequencer #(.N(N), .STEP_W(SW), .DECIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_steps(num_steps), .decim(decim), .dda_en(dda_en),
    .dda_init_n(dda_init_n), .v1_in(v1_in), .v2_in(v2_in),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_v1(smp_v1),
    .smp_v2(smp_v2), .smp_idx(smp_idx), .busy(busy), .done(done),
    .aborted(aborted)
  );

  // Clock / reset block.
  initial clk = 0;
  always #5 clk = ~clk;

  // One toy Euler-like step of the stand-in dynamics.
  function automatic logic [31:0] step_fn(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] x, y;
    x = $signed(a) + ($signed(b) >>> 2);
    y = $signed(b) - (x >>> 2);
    return {x, y};
  endfunction

  // Stand-in datapath register driven by the sequencer's en/init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v1 <= '0;
      dp_v2 <= '0;
    end else if (dda_en) begin
      if (!dda_init_n) begin
        dp_v1 <= ic1;
        dp_v2 <= ic2;
      end else begin
        dp_v1 <= step_fn(dp_v1, dp_v2) >> 16;
        dp_v2 <= step_fn(dp_v1, dp_v2) & 32'h0000ffff;
      end
    end
  end
  assign v1_in = dp_v1;
  assign v2_in = dp_v2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the list of emitted (idx, v1, v2) for one run.
  task automatic model_run(input int n, input int d, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [31:0] r;
    int dd;
    x = a;
    y = b;
    dd = (d == 0) ? 1 : d;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        r = step_fn(x, y);
        x = r[31:16];
        y = r[15:0];
      end
      if (k == 0 || k == n || (k % dd) == 0) exp_q.push_back({16'(k), x, y});
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cycles = 0; done_cnt = 0; en_cycles = 0; init_cycles = 0; acc_cnt = 0;
  endtask

  // Scoreboard / monitor: samples on the falling edge.
  initial begin
    logic [47:0] e, prev;
    bit hold_prev;
    hold_prev = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (dda_en) en_cycles++;
        if (dda_en && !dda_init_n) init_cycles++;
        if (!busy) check("en_low_when_idle", {63'd0, dda_en}, 64'd0);
        if (hold_prev && smp_valid)
          check("held_sample_stable", {16'd0, smp_idx, smp_v1, smp_v2}, {16'd0, prev});
        if (smp_valid && smp_ready) begin
          if (exp_q.size() == 0) check("sample_expected", 64'd0, 64'd1);
          else begin
            e = exp_q.pop_front();
            check("sample", {16'd0, smp_idx, smp_v1, smp_v2}, {16'd0, e});
            acc_cnt++;
          end
        end
        hold_prev = smp_valid && !smp_ready;
        prev = {smp_idx, smp_v1, smp_v2};
      end else hold_prev = 0;
    end
  end

  // Random consumer backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) smp_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_idle_drain();
    int i;
    for (i = 0; i < 5000; i++) begin
      tick();
      if (!busy) break;
    end
    if (i == 5000) check("run_timeout", 64'd1, 64'd0);
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !smp_valid) break;
      tick();
    end
  endtask

  task automatic start_run(input int n, input int d);
    num_steps = 16'(n);
    decim = 8'(d);
    start = 1;
    tick();
    start = 0;
    num_steps = 16'($urandom);
    decim = 8'($urandom);
  endtask

  // Full run: model, launch, completion checks.
  task automatic launch(input int n, input int d, input bit rnd);
    clear_counts();
    rand_ready = rnd;
    if (!rnd) smp_ready = 1;
    tick();
    start_run(n, d);
    wait_idle_drain();
    rand_ready = 0;
    smp_ready = 1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("idle_after_run", {63'd0, busy}, 64'd0);
    if (!rnd) begin
      check("busy_cycles", 64'(busy_cycles), 64'(3 + 2 * n));
      check("en_cycles", 64'(en_cycles), 64'(n + 1));
      check("init_cycles", 64'(init_cycles), 64'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] v1_a;
    int i, cnt, n, d;
    rst_n = 0; start = 0; abort = 0; smp_ready = 1;
    num_steps = 0; decim = 0; ic1 = 16'd100; ic2 = 16'd40;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_en", {63'd0, dda_en}, 64'd0);
    check("rst_init_n", {63'd0, dda_init_n}, 64'd1);
    check("rst_valid", {63'd0, smp_valid}, 64'd0);
    check("rst_fields", {16'd0, smp_idx, smp_v1, smp_v2}, 64'd0);
    check("rst_pulses", {62'd0, done, aborted}, 64'd0);
    rst_n = 1;

    // Hand-computed pins on the model's step function.
    check("pin_step_a", 64'(step_fn(16'd100, 16'd40)), {32'd0, 16'd110, 16'd13});
    check("pin_step_b", 64'(step_fn(16'd0, 16'hfff8)), {32'd0, 16'hfffe, 16'hfff9});

    model_run(4, 1, ic1, ic2);
    launch(4, 1, 0);

    model_run(7, 3, ic1, ic2);
    check("pin_decim_count", 64'(exp_q.size()), 64'd4);
    check("pin_decim_idx", {16'd0, exp_q[0][47:32], exp_q[1][47:32], exp_q[2][47:32]},
          {16'd0, 16'd0, 16'd3, 16'd6});
    check("pin_decim_last", 64'(exp_q[3][47:32]), 64'd7);
    launch(7, 3, 0);

    model_run(0, 1, ic1, ic2);
    launch(0, 1, 0);
    model_run(6, 0, ic1, ic2);
    launch(6, 0, 0);

    // Stall: consumer blocks for 10 cycles after the first sample.
    clear_counts();
    model_run(5, 1, ic1, ic2);
    smp_ready = 0;
    tick();
    start_run(5, 1);
    for (i = 0; i < 50 && !smp_valid; i++) tick();
    v1_a = '0;
    for (i = 0; i < 10; i++) begin
      tick();
      if (i == 4) v1_a = v1_in;
    end
    check("stall_idx_held", 64'(smp_idx), 64'd0);
    check("stall_en_low", {63'd0, dda_en}, 64'd0);
    check("stall_busy", {63'd0, busy}, 64'd1);
    check("stall_v1_frozen", 64'(v1_in), 64'(v1_a));
    check("stall_v1_step1", 64'(v1_in), 64'(step_fn(ic1, ic2) >> 16));
    smp_ready = 1;
    wait_idle_drain();
    check("stall_queue_drained", 64'(exp_q.size()), 64'd0);
    check("stall_done", 64'(done_cnt), 64'd1);
    check("stall_en_cycles", 64'(en_cycles), 64'd6);
    exp_q.delete();

    // start and abort together in IDLE: no run.
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    check("start_abort_idle", {62'd0, busy, aborted}, 64'd0);
    tick();
    check("start_abort_idle2", {62'd0, busy, smp_valid}, 64'd0);

    // Abort during the 20th step.
    clear_counts();
    model_run(100, 1, ic1, ic2);
    tick();
    start_run(100, 1);
    cnt = 0;
    for (i = 0; i < 200 && cnt < 20; i++) begin
      if (dda_en && dda_init_n) cnt++;
      if (cnt < 20) tick();
    end
    abort = 1;
    #1;
    check("abort_gates_en", {63'd0, dda_en}, 64'd0);
    tick();
    check("abort_to_idle", {63'd0, busy}, 64'd0);
    check("aborted_pulse", {63'd0, aborted}, 64'd1);
    check("abort_flush", {63'd0, smp_valid}, 64'd0);
    abort = 0;
    tick();
    check("aborted_one_cycle", {63'd0, aborted}, 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_samples", 64'(acc_cnt), 64'd20);
    exp_q.delete();
    model_run(3, 1, ic1, ic2);
    launch(3, 1, 0);

    // Asynchronous reset in the middle of a step.
    ic1 = 16'h0123; ic2 = 16'hfe00;
    tick();
    start_run(10, 1);
    for (i = 0; i < 50 && !(dda_en && dda_init_n); i++) tick();
    #2 rst_n = 0;
    #1;
    check("async_rst_busy", {61'd0, busy, done, aborted}, 64'd0);
    check("async_rst_en", {62'd0, dda_en, dda_init_n}, 64'd1);
    check("async_rst_buf", {15'd0, smp_valid, smp_idx, smp_v1, smp_v2}, 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1;
    model_run(5, 2, ic1, ic2);
    launch(5, 2, 0);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 12);
      d = $urandom_range(0, 4);
      ic1 = 16'($urandom);
      ic2 = 16'($urandom);
      model_run(n, d, ic1, ic2);
      launch(n, d, 1'(r % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
